// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter control block: mode values, button
// indices and the command selector used between decode and output registers.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'd0,
        MODE_AUTO_UP   = 2'd1,
        MODE_AUTO_DOWN = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_INC  = 2'd1,
        CMD_DEC  = 2'd2,
        CMD_RST  = 2'd3
    } cmd_e;

    localparam int NUM_BTN  = 4;
    localparam int BTN_INC  = 0;
    localparam int BTN_DEC  = 1;
    localparam int BTN_MODE = 2;
    localparam int BTN_RST  = 3;

    // Mode rotation; the unused encoding falls back to MANUAL.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_MANUAL:    next_mode = MODE_AUTO_UP;
            MODE_AUTO_UP:   next_mode = MODE_AUTO_DOWN;
            MODE_AUTO_DOWN: next_mode = MODE_MANUAL;
            default:        next_mode = MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_button_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for a vector of raw
// asynchronous buttons. press is high for one cycle per synced low->high edge.
module button_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] press
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                  prev_r;
    logic [WIDTH-1:0]                  synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain and edge history; reset clears history so a held button re-presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
            prev_r <= synced_s;
        end
    end

    assign press = synced_s & ~prev_r;

endmodule

// File: rtl/counter_ctrl.sv
// Button-driven counter controller: manual inc/dec/clear commands plus an
// auto-repeat mode that issues one inc or dec per CYCLES_PER_SECOND cycles.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_SECOND = 125_000_000,
    parameter int SYNC_STAGES       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] buttons,
    output logic       cmd_inc,
    output logic       cmd_dec,
    output logic       cmd_rst,
    output logic [1:0] mode
);

    localparam int TICK_W = (CYCLES_PER_SECOND > 1) ? $clog2(CYCLES_PER_SECOND) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_SECOND - 1);

    logic [NUM_BTN-1:0] press_s;
    mode_e              mode_r;
    mode_e              mode_nxt_s;
    logic [TICK_W-1:0]  tick_r;
    logic [TICK_W-1:0]  tick_nxt_s;
    logic               auto_s;
    logic               tick_hit_s;
    logic               manual_s;
    cmd_e               cmd_nxt_s;
    logic               cmd_inc_r;
    logic               cmd_dec_r;
    logic               cmd_rst_r;

    button_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (NUM_BTN)
    ) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (buttons),
        .press(press_s)
    );

    assign auto_s     = (mode_r == MODE_AUTO_UP) || (mode_r == MODE_AUTO_DOWN);
    assign tick_hit_s = auto_s && (tick_r == TICK_LAST);
    assign manual_s   = press_s[BTN_INC] | press_s[BTN_DEC] | press_s[BTN_RST];

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_MANUAL;
        end else begin
            mode_r <= mode_nxt_s;
        end
    end

    // Mode next-state: advance only on a mode-button press edge.
    always_comb begin
        mode_nxt_s = mode_r;
        if (press_s[BTN_MODE]) begin
            mode_nxt_s = next_mode(mode_r);
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Command decode: manual edges outrank the auto tick, which is dropped on a mode change.
    always_comb begin
        cmd_nxt_s = CMD_NONE;
        if (press_s[BTN_INC]) begin
            cmd_nxt_s = CMD_INC;
        end else if (press_s[BTN_DEC]) begin
            cmd_nxt_s = CMD_DEC;
        end else if (press_s[BTN_RST]) begin
            cmd_nxt_s = CMD_RST;
        end else if (tick_hit_s && !press_s[BTN_MODE]) begin
            case (mode_r)
                MODE_AUTO_UP:   cmd_nxt_s = CMD_INC;
                MODE_AUTO_DOWN: cmd_nxt_s = CMD_DEC;
                default:        cmd_nxt_s = CMD_NONE;
            endcase
        end else begin
            cmd_nxt_s = CMD_NONE;
        end
    end

    // Tick period restarts on any manual command or mode change; idle in MANUAL.
    always_comb begin
        tick_nxt_s = tick_r;
        if (!auto_s || manual_s || press_s[BTN_MODE]) begin
            tick_nxt_s = {TICK_W{1'b0}};
        end else if (tick_hit_s) begin
            tick_nxt_s = {TICK_W{1'b0}};
        end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
        end
    end

    // Tick counter and registered command pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r    <= {TICK_W{1'b0}};
            cmd_inc_r <= 1'b0;
            cmd_dec_r <= 1'b0;
            cmd_rst_r <= 1'b0;
        end else begin
            tick_r    <= tick_nxt_s;
            cmd_inc_r <= (cmd_nxt_s == CMD_INC);
            cmd_dec_r <= (cmd_nxt_s == CMD_DEC);
            cmd_rst_r <= (cmd_nxt_s == CMD_RST);
        end
    end

    assign cmd_inc = cmd_inc_r;
    assign cmd_dec = cmd_dec_r;
    assign cmd_rst = cmd_rst_r;
    assign mode    = mode_r;

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter CYCLES_PER_SECOND, default 125_000_000, auto-mode tick period in clk cycles (legal range >= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per button (legal range >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port buttons  input  4  raw asynchronous buttons: [0]=inc, [1]=dec, [2]=mode, [3]=reset.
REQ-006 SHALL have port cmd_inc  output  1  one-cycle increment pulse to counter.
REQ-007 SHALL have port cmd_dec  output  1  one-cycle decrement pulse to counter.
REQ-008 SHALL have port cmd_rst  output  1  one-cycle clear pulse to counter.
REQ-009 SHALL have port mode  output  2  current mode: 0=MANUAL, 1=AUTO_UP, 2=AUTO_DOWN; 3 never driven.

Function
REQ-010 SHALL synchronize each button through SYNC_STAGES flops, then detect rising edges (press = synced high, previous synced low).
REQ-011 SHALL register all cmd_* outputs; with SYNC_STAGES=2 a cmd pulse SHALL be visible after the 3rd rising clk edge counting the first edge that samples the raw button high.
REQ-012 SHALL produce exactly one pulse per press regardless of hold duration; a new pulse requires release (synced low for >= 1 cycle) and re-press.
REQ-013 SHALL assert at most one of cmd_inc/cmd_dec/cmd_rst in any cycle.
REQ-014 SHALL resolve simultaneous press edges with priority inc > dec > reset; losing edges are discarded, not queued.
REQ-015 SHALL advance mode on each buttons[2] press edge: MANUAL -> AUTO_UP -> AUTO_DOWN -> MANUAL; mode edge is independent of command priority (may coincide with a cmd pulse).
REQ-016 SHALL hold a tick counter of width $clog2(CYCLES_PER_SECOND), counting 0..CYCLES_PER_SECOND-1 and wrapping to 0, only in AUTO_UP/AUTO_DOWN; held at 0 in MANUAL.
REQ-017 SHALL, at tick counter terminal value, issue cmd_inc in AUTO_UP or cmd_dec in AUTO_DOWN on the following cycle.
REQ-018 SHALL give any manual press edge (inc/dec/reset) priority over a same-cycle auto tick; the tick pulse is dropped and the tick counter restarts at 0.
REQ-019 SHALL clear the tick counter to 0 on every mode change and on every manual command.
REQ-020 SHALL leave mode unchanged on a reset-button command.
REQ-021 SHALL never emit two auto pulses closer than CYCLES_PER_SECOND cycles apart.

Reset
REQ-022 SHALL, while rst_n low, asynchronously force cmd_inc=0, cmd_dec=0, cmd_rst=0, mode=MANUAL, tick counter=0, all synchronizer and edge-history flops=0.
REQ-023 SHALL, after rst_n deassertion, treat a button already held high as a new press (edge history cleared), producing one pulse.
REQ-024 SHALL abort any in-progress tick period on reset with no residual pulse.

Structure
REQ-025 SHALL take mode encodings (MODE_MANUAL/AUTO_UP/AUTO_DOWN) and button index constants (BTN_INC=0, BTN_DEC=1, BTN_MODE=2, BTN_RST=3) from shared package counter_ctrl_pkg.
REQ-026 SHALL implement synchronizer plus edge detector as sub-module button_sync_edge (parameter SYNC_STAGES, per-bit or vector), instantiated for all 4 buttons.
REQ-027 SHALL implement the mode FSM and tick counter in counter_ctrl itself.

Verification (bench uses CYCLES_PER_SECOND=4)
REQ-028 SHALL verify: buttons=0001 held 10 cycles from reset -> exactly one cmd_inc pulse, 3 edges after first sampling edge.
REQ-029 SHALL verify: buttons=1011 pressed in one cycle -> only cmd_inc pulses; then 1010 after release -> only cmd_dec.
REQ-030 SHALL verify: three buttons[2] presses -> mode 0->1->2->0; in mode 1 with no presses, cmd_inc every 4 cycles (5 pulses in 20 cycles).
REQ-031 SHALL verify: mode 2, buttons[0] press arriving same cycle as terminal tick -> single cmd_inc, no cmd_dec, next cmd_dec 4 cycles later.
REQ-032 SHALL verify: rst_n pulled low mid-period in mode 1 -> outputs 0 and mode 0 immediately (before next clk edge); no pulse after release with buttons=0.
REQ-033 SHALL verify: buttons=1000 in mode 1 -> single cmd_rst, mode stays 1, next cmd_inc 4 cycles later.
